// File: rtl/vga_frame_buffer.sv
// rtl/vga_frame_buffer.sv - single-port video RAM shared by display fetch and buffered CPU access
module vga_frame_buffer #(
    parameter int ADDR_W     = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        pixel_state,
    input  logic [ADDR_W-1:0] vgad_addr,
    output logic [15:0]       vgad_data,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ready,
    input  logic              cpu_re,
    output logic              cpu_rd_busy,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_rvalid
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = FIFO_DEPTH[PTR_W:0];

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_FETCH,
        SLOT_DRAIN,
        SLOT_READ
    } slot_t;

    slot_t             slot;
    logic [15:0]       mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [15:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign cpu_ready  = !fifo_full;
    assign push       = cpu_we && !fifo_full;
    assign pop        = (slot == SLOT_DRAIN);

    // Slot arbitration: display fetch, then write drain, then the pending CPU read.
    // Reset forces an idle slot so discarded FIFO entries never reach the RAM.
    always_comb begin
        slot = SLOT_IDLE;
        if (reset) begin
            slot = SLOT_IDLE;
        end else if (enable && pixel_state == 2'b00) begin
            slot = SLOT_FETCH;
        end else if (!fifo_empty) begin
            slot = SLOT_DRAIN;
        end else if (cpu_rd_busy) begin
            slot = SLOT_READ;
        end
    end

    // Single RAM address port, steered by the slot owner.
    always_comb begin
        ram_addr = vgad_addr;
        ram_we   = 1'b0;
        case (slot)
            SLOT_DRAIN: begin
                ram_addr = fifo_addr[rd_ptr];
                ram_we   = 1'b1;
            end
            SLOT_READ: begin
                ram_addr = rd_addr;
            end
            default: begin
                ram_addr = vgad_addr;
            end
        endcase
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= fifo_data[rd_ptr];
        end
    end

    // Registered read data: each consumer's register only loads on its own slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            vgad_data  <= '0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= (slot == SLOT_READ);
            if (slot == SLOT_FETCH) begin
                vgad_data <= mem[ram_addr];
            end
            if (slot == SLOT_READ) begin
                cpu_rdata <= mem[ram_addr];
            end
        end
    end

    // Write FIFO storage; only the pointers need reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_addr;
            fifo_data[wr_ptr] <= cpu_wdata;
        end
    end

    // Write FIFO pointers and occupancy; simultaneous push and pop keep count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read request latch; the read waits until every earlier write has drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rd_busy <= 1'b0;
            rd_addr     <= '0;
        end else if (slot == SLOT_READ) begin
            cpu_rd_busy <= 1'b0;
        end else if (cpu_re && !cpu_rd_busy) begin
            cpu_rd_busy <= 1'b1;
            rd_addr     <= cpu_addr;
        end
    end

endmodule

// File: tb/tb_vga_frame_buffer.sv
// tb/tb_vga_frame_buffer.sv - randomized self-checking bench with a queue-based memory model
module tb_vga_frame_buffer;

    localparam int AW    = 15;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    pixel_state = 2'b01;
    logic [AW-1:0] vgad_addr = '0;
    logic [15:0]   vgad_data;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [15:0]   cpu_wdata = '0;
    logic          cpu_ready;
    logic          cpu_re = 1'b0;
    logic          cpu_rd_busy;
    logic [15:0]   cpu_rdata;
    logic          cpu_rvalid;

    int checks = 0;
    int failures = 0;

    vga_frame_buffer #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pixel_state(pixel_state),
        .vgad_addr(vgad_addr), .vgad_data(vgad_data),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .cpu_re(cpu_re), .cpu_rd_busy(cpu_rd_busy), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    logic [15:0]   m_mem [0:(1<<AW)-1];
    wr_t           m_q[$];
    logic          m_busy = 1'b0;
    logic [AW-1:0] m_raddr = '0;
    logic [15:0]   m_vgad = '0;
    logic [15:0]   m_rdata = '0;
    logic          m_rvalid = 1'b0;

    // Advance the reference model by one clock using the current inputs, then the DUT.
    task automatic step();
        logic accept_we;
        logic accept_re;
        if (reset) begin
            m_q.delete();
            m_busy = 1'b0;
            m_vgad = '0;
            m_rdata = '0;
            m_rvalid = 1'b0;
        end else begin
            accept_we = cpu_we && (m_q.size() < DEPTH);
            accept_re = cpu_re && !m_busy;
            m_rvalid = 1'b0;
            if (enable && pixel_state == 2'b00) begin
                m_vgad = m_mem[vgad_addr];
            end else if (m_q.size() != 0) begin
                m_mem[m_q[0].a] = m_q[0].d;
                void'(m_q.pop_front());
            end else if (m_busy) begin
                m_rdata = m_mem[m_raddr];
                m_rvalid = 1'b1;
                m_busy = 1'b0;
            end
            if (accept_we) m_q.push_back('{cpu_addr, cpu_wdata});
            if (accept_re) begin
                m_busy = 1'b1;
                m_raddr = cpu_addr;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle read request and wait (bounded) for the data pulse; lat = -1 on timeout.
    task automatic cpu_read(input logic [AW-1:0] a, output logic [15:0] d, output int lat);
        cpu_re = 1'b1;
        cpu_addr = a;
        step();
        cpu_re = 1'b0;
        lat = 1;
        d = 'x;
        while (!cpu_rvalid && lat < 40) begin
            step();
            lat++;
        end
        if (cpu_rvalid) d = cpu_rdata;
        else lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (vgad_data !== 16'h0) begin failures++; $display("FAIL reset_vgad got=%h exp=0000", vgad_data); end
        checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cpu_ready); end
        checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", cpu_rvalid); end
        checks++; if (cpu_rd_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", cpu_rd_busy); end
    endtask

    task automatic test_write_fetch();
        enable = 1'b0;
        cpu_we = 1'b1; cpu_addr = 15'h0005; cpu_wdata = 16'h1234;
        step();
        cpu_we = 1'b0;
        step();
        checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL wf_ready got=%b exp=1", cpu_ready); end
        enable = 1'b1; pixel_state = 2'b00; vgad_addr = 15'h0005;
        step();
        checks++; if (vgad_data !== 16'h1234) begin failures++; $display("FAIL wf_fetch got=%h exp=1234", vgad_data); end
        pixel_state = 2'b01;
        for (int i = 0; i < 3; i++) begin
            vgad_addr = AW'($urandom);
            step();
            checks++; if (vgad_data !== 16'h1234) begin failures++; $display("FAIL wf_hold got=%h exp=1234", vgad_data); end
        end
    endtask

    task automatic test_fifo_full();
        logic [15:0] wd [4];
        logic [15:0] d;
        int lat;
        enable = 1'b1; pixel_state = 2'b00; vgad_addr = 15'h0005;
        for (int i = 0; i < 5; i++) begin
            checks++; if (cpu_ready !== (i < 4)) begin failures++; $display("FAIL full_ready_%0d got=%b exp=%b", i, cpu_ready, i < 4); end
            cpu_we = 1'b1;
            cpu_addr = AW'(15'h0100 + (i % 4));
            cpu_wdata = 16'($urandom);
            if (i < 4) wd[i] = cpu_wdata;
            step();
        end
        cpu_we = 1'b0;
        checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL full_held got=%b exp=0", cpu_ready); end
        checks++; if (vgad_data !== 16'h1234) begin failures++; $display("FAIL full_vgad got=%h exp=1234", vgad_data); end
        pixel_state = 2'b01;
        step();
        checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL full_first_pop got=%b exp=1", cpu_ready); end
        step(); step(); step();
        for (int i = 0; i < 4; i++) begin
            cpu_read(AW'(15'h0100 + i), d, lat);
            checks++; if (d !== wd[i]) begin failures++; $display("FAIL full_order_%0d got=%h exp=%h lat=%0d", i, d, wd[i], lat); end
        end
    endtask

    task automatic test_coherency();
        int pulses = 0;
        logic [15:0] seen = '0;
        enable = 1'b0;
        cpu_we = 1'b1; cpu_wdata = 16'hBEEF; cpu_addr = 15'h7FFF; cpu_re = 1'b1;
        step();
        cpu_we = 1'b0; cpu_addr = 15'h0005;
        for (int i = 0; i < 8; i++) begin
            cpu_re = (i == 0);
            step();
            if (cpu_rvalid) begin
                pulses++;
                seen = cpu_rdata;
            end
        end
        cpu_re = 1'b0;
        checks++; if (pulses != 1) begin failures++; $display("FAIL coh_pulses got=%0d exp=1", pulses); end
        checks++; if (seen !== 16'hBEEF) begin failures++; $display("FAIL coh_data got=%h exp=beef", seen); end
        checks++; if (cpu_rd_busy !== 1'b0) begin failures++; $display("FAIL coh_busy got=%b exp=0", cpu_rd_busy); end
    endtask

    task automatic test_fetch_interference();
        int lat = -1;
        logic prev_fetch;
        enable = 1'b1;
        cpu_re = 1'b1; cpu_addr = 15'h0005;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            pixel_state = i[0] ? 2'b00 : 2'b01;
            vgad_addr = AW'(15'h0100 + $urandom_range(0, 3));
            prev_fetch = (pixel_state == 2'b00);
            step();
            cpu_re = 1'b0;
            checks++; if (vgad_data !== m_vgad) begin failures++; $display("FAIL intf_vgad_%0d got=%h exp=%h", i, vgad_data, m_vgad); end
            if (cpu_rvalid) begin
                lat = i + 1;
                checks++; if (prev_fetch) begin failures++; $display("FAIL intf_slot got=fetch exp=free"); end
                checks++; if (cpu_rdata !== 16'h1234) begin failures++; $display("FAIL intf_data got=%h exp=1234", cpu_rdata); end
            end
        end
        checks++; if (lat != 3) begin failures++; $display("FAIL intf_latency got=%0d exp=3", lat); end
        pixel_state = 2'b01;
    endtask

    task automatic test_mid_reset();
        logic [15:0] d;
        int lat;
        int pulses = 0;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_we = 1'b1; cpu_addr = AW'(15'h0300 + i); cpu_wdata = 16'hA000 + 16'(i);
            step();
        end
        cpu_we = 1'b0;
        step();
        enable = 1'b1; pixel_state = 2'b00;
        for (int i = 0; i < 3; i++) begin
            cpu_we = 1'b1; cpu_addr = AW'(15'h0300 + i); cpu_wdata = 16'($urandom) | 16'h0001;
            cpu_re = (i == 2);
            step();
        end
        cpu_we = 1'b0; cpu_re = 1'b0;
        checks++; if (cpu_rd_busy !== 1'b1) begin failures++; $display("FAIL mr_pending got=%b exp=1", cpu_rd_busy); end
        reset = 1'b1; enable = 1'b0;
        step();
        reset = 1'b0;
        checks++; if (cpu_rd_busy !== 1'b0) begin failures++; $display("FAIL mr_busy got=%b exp=0", cpu_rd_busy); end
        checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL mr_ready got=%b exp=1", cpu_ready); end
        checks++; if (vgad_data !== 16'h0) begin failures++; $display("FAIL mr_vgad got=%h exp=0000", vgad_data); end
        for (int i = 0; i < 6; i++) begin
            step();
            if (cpu_rvalid) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL mr_rvalid got=%0d exp=0", pulses); end
        for (int i = 0; i < 3; i++) begin
            cpu_read(AW'(15'h0300 + i), d, lat);
            checks++; if (d !== 16'hA000 + 16'(i)) begin failures++; $display("FAIL mr_ram_%0d got=%h exp=%h", i, d, 16'hA000 + 16'(i)); end
        end
    endtask

    task automatic test_random();
        enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cpu_we = 1'b1; cpu_addr = AW'(15'h0040 + i); cpu_wdata = 16'($urandom);
            step();
        end
        cpu_we = 1'b0;
        step(); step();
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            pixel_state = 2'($urandom);
            vgad_addr = AW'(15'h0040 + $urandom_range(0, 15));
            cpu_we = $urandom_range(0, 1);
            cpu_addr = AW'(15'h0040 + $urandom_range(0, 15));
            cpu_wdata = 16'($urandom);
            cpu_re = ($urandom_range(0, 3) == 0);
            step();
            checks++; if (vgad_data !== m_vgad) begin failures++; $display("FAIL rnd_vgad_%0d got=%h exp=%h", i, vgad_data, m_vgad); end
            checks++; if (cpu_ready !== (m_q.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready_%0d got=%b exp=%b", i, cpu_ready, m_q.size() < DEPTH); end
            checks++; if (cpu_rd_busy !== m_busy) begin failures++; $display("FAIL rnd_busy_%0d got=%b exp=%b", i, cpu_rd_busy, m_busy); end
            checks++; if (cpu_rvalid !== m_rvalid) begin failures++; $display("FAIL rnd_rvalid_%0d got=%b exp=%b", i, cpu_rvalid, m_rvalid); end
            checks++; if (cpu_rdata !== m_rdata) begin failures++; $display("FAIL rnd_rdata_%0d got=%h exp=%h", i, cpu_rdata, m_rdata); end
        end
        cpu_we = 1'b0; cpu_re = 1'b0; enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_fetch();
        test_fifo_full();
        test_coherency();
        test_fetch_interference();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
